// File: rtl/fmul_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface fmul_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         ovf;
  logic         udf;

  modport master (
    output in_valid, a, b, rm, out_ready,
    input  in_ready, out_valid, c, ovf, udf
  );

  modport slave (
    input  in_valid, a, b, rm, out_ready,
    output in_ready, out_valid, c, ovf, udf
  );
endinterface

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier (unpack, multiply, normalise/round/pack)
// with a single global advance signal providing valid/ready back-pressure.
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic   clk,
  input  logic   rst_n,
  fmul_if.slave  io
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int MW1  = MAN_W + 1;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  logic adv;

  // Stage 1: unpacked operands
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q,  s1_sign_d;
  logic                  s1_zero_q,  s1_zero_d;
  logic                  s1_inf_q,   s1_inf_d;
  logic signed [EW2-1:0] s1_esum_q,  s1_esum_d;
  logic [MAN_W:0]        s1_siga_q,  s1_siga_d;
  logic [MAN_W:0]        s1_sigb_q,  s1_sigb_d;
  logic                  s1_rm_q,    s1_rm_d;

  // Stage 2: raw significand product
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_sign_q,  s2_sign_d;
  logic                  s2_zero_q,  s2_zero_d;
  logic                  s2_inf_q,   s2_inf_d;
  logic signed [EW2-1:0] s2_esum_q,  s2_esum_d;
  logic [PW-1:0]         s2_prod_q,  s2_prod_d;
  logic                  s2_rm_q,    s2_rm_d;

  // Stage 3: packed result
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          c_q,         c_d;
  logic                  ovf_q,       ovf_d;
  logic                  udf_q,       udf_d;

  logic [EXP_W-1:0]      ea, eb;
  logic                  top;
  logic [MAN_W-1:0]      man;
  logic                  guard, sticky, round_up;
  logic [MAN_W:0]        man_r;
  logic signed [EW2-1:0] e_r;

  assign adv         = io.out_ready | ~out_valid_q;
  assign io.in_ready = adv;

  always_comb begin
    ea         = io.a[W-2 -: EXP_W];
    eb         = io.b[W-2 -: EXP_W];
    s1_valid_d = io.in_valid;
    s1_sign_d  = io.a[W-1] ^ io.b[W-1];
    s1_zero_d  = (ea == '0) | (eb == '0);
    s1_inf_d   = (&ea) | (&eb);
    s1_esum_d  = {2'b00, ea} + {2'b00, eb} - EW2'(BIAS);
    s1_siga_d  = {1'b1, io.a[MAN_W-1:0]};
    s1_sigb_d  = {1'b1, io.b[MAN_W-1:0]};
    s1_rm_d    = io.rm;
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_zero_d  = s1_zero_q;
    s2_inf_d   = s1_inf_q;
    s2_esum_d  = s1_esum_q;
    s2_prod_d  = PW'(s1_siga_q) * PW'(s1_sigb_q);
    s2_rm_d    = s1_rm_q;
  end

  // Product lies in [1,4); a set top bit means one extra exponent step.
  always_comb begin
    top      = s2_prod_q[PW-1];
    man      = top ? s2_prod_q[2*MAN_W:MAN_W+1] : s2_prod_q[2*MAN_W-1:MAN_W];
    guard    = top ? s2_prod_q[MAN_W]           : s2_prod_q[MAN_W-1];
    sticky   = top ? |s2_prod_q[MAN_W-1:0]      : |s2_prod_q[MAN_W-2:0];
    round_up = s2_rm_q & guard & (sticky | man[0]);
    man_r    = {1'b0, man} + MW1'(round_up);
    e_r      = s2_esum_q + EW2'(top) + EW2'(man_r[MAN_W]);

    out_valid_d = s2_valid_q;
    ovf_d       = 1'b0;
    udf_d       = 1'b0;
    c_d         = {s2_sign_q, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};

    if (s2_zero_q) begin
      c_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (s2_inf_q) begin
      c_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_r >= E_MAX) begin
      c_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (e_r <= E_ZERO) begin
      c_d   = {s2_sign_q, {(W-1){1'b0}}};
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_esum_q   <= '0;
      s1_siga_q   <= '0;
      s1_sigb_q   <= '0;
      s1_rm_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_esum_q   <= '0;
      s2_prod_q   <= '0;
      s2_rm_q     <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_inf_q    <= s1_inf_d;
      s1_esum_q   <= s1_esum_d;
      s1_siga_q   <= s1_siga_d;
      s1_sigb_q   <= s1_sigb_d;
      s1_rm_q     <= s1_rm_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_inf_q    <= s2_inf_d;
      s2_esum_q   <= s2_esum_d;
      s2_prod_q   <= s2_prod_d;
      s2_rm_q     <= s2_rm_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.c         = c_q;
  assign io.ovf       = ovf_q;
  assign io.udf       = udf_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed-vector bench for fmul_pipe: FP32 and FP16 instances, back-pressure and reset.
module tb_fmul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fmul_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fmul_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .io(bus32));
  fmul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .io(bus16));

  // Issues one operand pair and waits for its result; lat = -1 on timeout.
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic rm,
                         output logic [31:0] c, output logic ovf, output logic udf,
                         output int lat);
    @(negedge clk);
    bus32.in_valid  = 1'b1;
    bus32.a         = a;
    bus32.b         = b;
    bus32.rm        = rm;
    bus32.out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus32.in_valid = 1'b0;
      lat++;
    end while (!bus32.out_valid && lat < 20);
    if (!bus32.out_valid) lat = -1;
    c   = bus32.c;
    ovf = bus32.ovf;
    udf = bus32.udf;
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] c, output logic ovf, output int lat);
    @(negedge clk);
    bus16.in_valid  = 1'b1;
    bus16.a         = a;
    bus16.b         = b;
    bus16.rm        = 1'b1;
    bus16.out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus16.in_valid = 1'b0;
      lat++;
    end while (!bus16.out_valid && lat < 20);
    if (!bus16.out_valid) lat = -1;
    c   = bus16.c;
    ovf = bus16.ovf;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.rm        = 1'b0;
    bus32.out_ready = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.rm        = 1'b0;
    bus16.out_ready = 1'b1;
    #12;
    n_vec++;
    if ({bus32.out_valid, bus32.c, bus32.ovf, bus32.udf} !== 35'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state: got valid=%b c=%h ovf=%b udf=%b, expected all 0",
               bus32.out_valid, bus32.c, bus32.ovf, bus32.udf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus32.in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus32.in_ready);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va[12], vb[12], vc[12];
    logic        vrm[12], vovf[12], vudf[12];
    logic [31:0] c;
    logic        ovf, udf;
    int          lat;
    va   = '{32'h3F800000, 32'h3FC00001, 32'h3FC00001, 32'h7F000000, 32'hFF800000, 32'h7F800000,
             32'h00800000, 32'h80000000, 32'h40000000, 32'h3F800001, 32'h3F800003, 32'h3F800001};
    vb   = '{32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h00000000,
             32'h00800000, 32'h3F800000, 32'hC0400000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000};
    vrm  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vc   = '{32'h3F800000, 32'h40100000, 32'h40100001, 32'h7F800000, 32'hFF800000, 32'h00000000,
             32'h00000000, 32'h80000000, 32'hC0C00000, 32'h3FC00002, 32'h3FC00004, 32'h3FC00001};
    vovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vudf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      do_op32(va[i], vb[i], vrm[i], c, ovf, udf, lat);
      n_vec++;
      if (lat !== 3) begin
        n_err++;
        $display("[TB] FAIL arith[%0d].latency: got %0d expected 3", i, lat);
      end
      n_vec++;
      if (c !== vc[i]) begin
        n_err++;
        $display("[TB] FAIL arith[%0d].c: got %h expected %h", i, c, vc[i]);
      end
      n_vec++;
      if ({ovf, udf} !== {vovf[i], vudf[i]}) begin
        n_err++;
        $display("[TB] FAIL arith[%0d].flags: got ovf=%b udf=%b expected ovf=%b udf=%b",
                 i, ovf, udf, vovf[i], vudf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa[6], xc[6];
    logic        xovf[6];
    logic [31:0] held_c;
    logic        held_ovf, held_udf;
    int          sent = 0, recv = 0, stall_left = 0, cyc = 0;
    bit          stalled = 1'b0;
    xa[0] = 32'h7F000000;
    xc[0] = 32'h7F800000;
    xovf[0] = 1'b1;
    for (int i = 1; i < 6; i++) begin
      xa[i]   = 32'h40000000 + i * 32'h00011111;
      xc[i]   = xa[i] + 32'h00800000;
      xovf[i] = 1'b0;
    end
    held_c   = '0;
    held_ovf = 1'b0;
    held_udf = 1'b0;
    bus32.b  = 32'h40000000;
    bus32.rm = 1'b1;
    while (recv < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!stalled && bus32.out_valid) begin
        stalled    = 1'b1;
        stall_left = 4;
        held_c     = bus32.c;
        held_ovf   = bus32.ovf;
        held_udf   = bus32.udf;
      end
      bus32.out_ready = (stall_left == 0);
      bus32.in_valid  = (sent < 6);
      if (sent < 6) bus32.a = xa[sent];
      #1;
      if (stall_left > 0) begin
        n_vec++;
        if (bus32.in_ready !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL stall_in_ready: got %b expected 0", bus32.in_ready);
        end
        n_vec++;
        if ({bus32.out_valid, bus32.c, bus32.ovf, bus32.udf} !== {1'b1, held_c, held_ovf, held_udf}) begin
          n_err++;
          $display("[TB] FAIL stall_hold: got valid=%b c=%h ovf=%b udf=%b expected 1 %h %b %b",
                   bus32.out_valid, bus32.c, bus32.ovf, bus32.udf, held_c, held_ovf, held_udf);
        end
        stall_left--;
      end
      if (bus32.out_valid && bus32.out_ready) begin
        n_vec++;
        if ({bus32.c, bus32.ovf, bus32.udf} !== {xc[recv], xovf[recv], 1'b0}) begin
          n_err++;
          $display("[TB] FAIL stream[%0d]: got c=%h ovf=%b udf=%b expected c=%h ovf=%b udf=0",
                   recv, bus32.c, bus32.ovf, bus32.udf, xc[recv], xovf[recv]);
        end
        recv++;
      end
      if (bus32.in_valid && bus32.in_ready) sent++;
    end
    @(negedge clk);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    n_vec++;
    if (recv !== 6 || !stalled) begin
      n_err++;
      $display("[TB] FAIL stream_count: got %0d results (stalled=%b) expected 6", recv, stalled);
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus32.out_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL stream_extra: got out_valid=%b c=%h expected no further result",
                 bus32.out_valid, bus32.c);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fp16();
    logic [15:0] c;
    logic        ovf;
    int          lat = 0;
    @(negedge clk);
    bus16.in_valid  = 1'b1;
    bus16.a         = 16'h3C00;
    bus16.b         = 16'h3C00;
    bus16.rm        = 1'b1;
    bus16.out_ready = 1'b0;
    do begin
      @(negedge clk);
      bus16.in_valid = 1'b0;
      lat++;
    end while (!bus16.out_valid && lat < 20);
    n_vec++;
    if (lat !== 3 || bus16.out_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL fp16_latency: got %0d expected 3", lat);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus16.in_ready, bus16.out_valid, bus16.c, bus16.ovf, bus16.udf} !== {1'b0, 1'b1, 16'h3C00, 1'b0, 1'b0}) begin
        n_err++;
        $display("[TB] FAIL fp16_stall[%0d]: got in_ready=%b valid=%b c=%h ovf=%b udf=%b expected 0 1 3c00 0 0",
                 i, bus16.in_ready, bus16.out_valid, bus16.c, bus16.ovf, bus16.udf);
      end
      @(negedge clk);
    end
    bus16.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus16.out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL fp16_drain: got out_valid=%b expected 0", bus16.out_valid);
    end
    do_op16(16'h4000, 16'hC200, c, ovf, lat);
    n_vec++;
    if ({lat == 3, c, ovf} !== {1'b1, 16'hC600, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL fp16_mul: got lat=%0d c=%h ovf=%b expected 3 c600 0", lat, c, ovf);
    end
    do_op16(16'h7800, 16'h7800, c, ovf, lat);
    n_vec++;
    if ({lat == 3, c, ovf} !== {1'b1, 16'h7C00, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL fp16_ovf: got lat=%0d c=%h ovf=%b expected 3 7c00 1", lat, c, ovf);
    end
  endtask

  task automatic test_reset_midflight();
    bus32.b         = 32'h3F800000;
    bus32.rm        = 1'b1;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.a        = 32'h3F800000;
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    n_vec++;
    if (bus32.out_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL midflight_pre: got out_valid=%b expected 1", bus32.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus32.out_valid, bus32.c, bus32.in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL midflight_reset: got valid=%b c=%h in_ready=%b expected 0 0 1",
               bus32.out_valid, bus32.c, bus32.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
        n_err++;
        $display("[TB] FAIL midflight_stale[%0d]: got valid=%b in_ready=%b expected 0 1",
                 i, bus32.out_valid, bus32.in_ready);
      end
    end
  endtask

  initial begin
    $display("[TB] starting fmul_pipe bench");
    test_reset();
    test_arith();
    test_back_to_back();
    test_fp16();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
